fetch_stage: RTL and testbench

Instruction-fetch stage sitting directly upstream of the instruction memory (`pc_mem`) and downstream of nothing but reset. It owns the program counter and drives the instruction memory's read address. It registers the combinationally returned instruction into the IF/ID pipeline register. It handles stall, branch redirect with squash, and HALT detection through a small boot/run/halt state machine.

---
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage.sv | 139 +++++++++++++
 tb/tb_fetch_stage.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port between the fetch stage (master) and the memory (slave).
// Reads are combinational: imem_data answers imem_addr in the same cycle.
interface fetch_stage_if #(
    parameter int ADDR_WIDTH = 16
) ();
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_en;
    logic                  imem_wr;
    logic [15:0]           imem_data;

    modport master (
        output imem_addr,
        output imem_en,
        output imem_wr,
        input  imem_data
    );

    modport slave (
        input  imem_addr,
        input  imem_en,
        input  imem_wr,
        output imem_data
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads instruction memory combinationally and
// registers the result into IF/ID, with stall, branch squash and HALT via BOOT/RUN/HALTED.
module fetch_stage #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h0000,
    parameter logic [15:0]           NOP_INSTR  = 16'h0800
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    fetch_stage_if.master         imem,
    output logic [15:0]           if_id_instr,
    output logic [ADDR_WIDTH-1:0] if_id_pc_plus2,
    output logic                  if_id_valid,
    output logic                  halted,
    output logic                  misaligned
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(2);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]           instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] pc_plus2_q, pc_plus2_d;
    logic                  valid_q, valid_d;
    logic                  halted_q, halted_d;
    logic                  misaligned_q, misaligned_d;
    logic                  en_q, en_d;

    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  is_halt;

    assign pc_inc      = pc_q + PC_STEP;
    assign redirect_pc = {branch_target[ADDR_WIDTH-1:1], 1'b0};
    assign is_halt     = (imem.imem_data[15:11] == 5'b00000);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc_plus2_d   = pc_plus2_q;
        valid_d      = valid_q;
        halted_d     = halted_q;
        misaligned_d = misaligned_q;
        en_d         = en_q;

        case (state_q)
            BOOT: begin
                state_d  = RUN;
                en_d     = 1'b1;
                halted_d = 1'b0;
            end

            RUN: begin
                if (branch_taken) begin
                    pc_d         = redirect_pc;
                    instr_d      = NOP_INSTR;
                    valid_d      = 1'b0;
                    misaligned_d = misaligned_q | branch_target[0];
                end else if (!stall) begin
                    instr_d    = imem.imem_data;
                    pc_plus2_d = pc_inc;
                    valid_d    = 1'b1;
                    // HALT is delivered to decode but the PC parks on its address
                    if (is_halt) begin
                        state_d  = HALTED;
                        en_d     = 1'b0;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end

            HALTED: begin
                if (branch_taken) begin
                    pc_d         = redirect_pc;
                    instr_d      = NOP_INSTR;
                    valid_d      = 1'b0;
                    misaligned_d = misaligned_q | branch_target[0];
                    state_d      = RUN;
                    en_d         = 1'b1;
                    halted_d     = 1'b0;
                end else if (!stall) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end

            default: begin
                state_d  = BOOT;
                en_d     = 1'b0;
                halted_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            pc_plus2_q   <= '0;
            valid_q      <= 1'b0;
            halted_q     <= 1'b0;
            misaligned_q <= 1'b0;
            en_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc_plus2_q   <= pc_plus2_d;
            valid_q      <= valid_d;
            halted_q     <= halted_d;
            misaligned_q <= misaligned_d;
            en_q         <= en_d;
        end
    end

    assign imem.imem_addr = pc_q;
    assign imem.imem_en   = en_q;
    assign imem.imem_wr   = 1'b0;

    assign if_id_instr    = instr_q;
    assign if_id_pc_plus2 = pc_plus2_q;
    assign if_id_valid    = valid_q;
    assign halted         = halted_q;
    assign misaligned     = misaligned_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural instruction memory plus a queue of
// expected IF/ID captures pushed at fetch time and popped after the capturing edge.
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        halted;
    logic        misaligned;

    logic [15:0] mem [0:32767];

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pcp2;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    fetch_stage_if #(.ADDR_WIDTH(16)) bus ();

    assign bus.imem_data = mem[bus.imem_addr[15:1]];

    fetch_stage #(
        .ADDR_WIDTH(16),
        .RESET_PC  (16'h0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (bus.master),
        .if_id_instr   (if_id_instr),
        .if_id_pc_plus2(if_id_pc_plus2),
        .if_id_valid   (if_id_valid),
        .halted        (halted),
        .misaligned    (misaligned)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic [15:0] addr);
        exp_t x;
        x.instr = mem[addr[15:1]];
        x.pcp2  = addr + 16'd2;
        q.push_back(x);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        branch_taken = 1'b1;
        branch_target = 16'h0100;
        stall = 1'b1;
        tick();
        tick();
        branch_taken = 1'b0;
        stall = 1'b0;
        n_cmp++;
        if ({bus.imem_en, bus.imem_wr, if_id_valid, halted, misaligned} !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_flags: got en/wr/valid/halted/mis=%b want 00000",
                     {bus.imem_en, bus.imem_wr, if_id_valid, halted, misaligned});
        end
        n_cmp++;
        if ({bus.imem_addr, if_id_instr, if_id_pc_plus2} !== {16'h0000, NOP, 16'h0000}) begin
            n_err++;
            $display("FAIL reset_regs: got pc=%h instr=%h pc2=%h want 0000 %h 0000",
                     bus.imem_addr, if_id_instr, if_id_pc_plus2, NOP);
        end
    endtask

    task automatic test_seq_fetch();
        rst_n = 1'b1;
        n_cmp++;
        if (bus.imem_en !== 1'b0) begin
            n_err++;
            $display("FAIL boot_en: got %b want 0", bus.imem_en);
        end
        tick();
        n_cmp++;
        if ({bus.imem_en, if_id_valid, bus.imem_addr} !== {1'b1, 1'b0, 16'h0000}) begin
            n_err++;
            $display("FAIL run_entry: got en=%b valid=%b pc=%h want 1 0 0000",
                     bus.imem_en, if_id_valid, bus.imem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            sb_push(bus.imem_addr);
            tick();
            e = q.pop_front();
            n_cmp++;
            if ({if_id_valid, if_id_instr, if_id_pc_plus2} !== {1'b1, e.instr, e.pcp2}) begin
                n_err++;
                $display("FAIL seq_fetch%0d: got v=%b instr=%h pc2=%h want v=1 instr=%h pc2=%h",
                         i, if_id_valid, if_id_instr, if_id_pc_plus2, e.instr, e.pcp2);
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({bus.imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid} !==
                {16'h0006, 16'h4002, 16'h0006, 1'b1}) begin
                n_err++;
                $display("FAIL stall_hold%0d: got pc=%h instr=%h pc2=%h v=%b want 0006 4002 0006 1",
                         i, bus.imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid);
            end
        end
        stall = 1'b0;
        sb_push(16'h0006);
        tick();
        e = q.pop_front();
        n_cmp++;
        if ({if_id_valid, if_id_instr, if_id_pc_plus2} !== {1'b1, e.instr, e.pcp2}) begin
            n_err++;
            $display("FAIL stall_release: got v=%b instr=%h pc2=%h want v=1 instr=%h pc2=%h",
                     if_id_valid, if_id_instr, if_id_pc_plus2, e.instr, e.pcp2);
        end
    endtask

    task automatic test_branch_over_stall();
        branch_taken = 1'b1;
        branch_target = 16'h0040;
        stall = 1'b1;
        tick();
        branch_taken = 1'b0;
        stall = 1'b0;
        n_cmp++;
        if ({bus.imem_addr, if_id_valid, if_id_instr} !== {16'h0040, 1'b0, NOP}) begin
            n_err++;
            $display("FAIL branch_squash: got pc=%h v=%b instr=%h want 0040 0 %h",
                     bus.imem_addr, if_id_valid, if_id_instr, NOP);
        end
        sb_push(16'h0040);
        tick();
        e = q.pop_front();
        n_cmp++;
        if ({if_id_valid, if_id_instr, if_id_pc_plus2} !== {1'b1, e.instr, 16'h0042}) begin
            n_err++;
            $display("FAIL branch_target_fetch: got v=%b instr=%h pc2=%h want v=1 instr=%h pc2=0042",
                     if_id_valid, if_id_instr, if_id_pc_plus2, e.instr);
        end
    endtask

    task automatic test_odd_target();
        n_cmp++;
        if (misaligned !== 1'b0) begin
            n_err++;
            $display("FAIL misaligned_pre: got %b want 0", misaligned);
        end
        branch_taken = 1'b1;
        branch_target = 16'h0033;
        tick();
        branch_taken = 1'b0;
        n_cmp++;
        if ({bus.imem_addr, misaligned, if_id_valid} !== {16'h0032, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL odd_target: got pc=%h mis=%b v=%b want 0032 1 0",
                     bus.imem_addr, misaligned, if_id_valid);
        end
        for (int i = 0; i < 3; i++) begin
            sb_push(bus.imem_addr);
            tick();
            e = q.pop_front();
            n_cmp++;
            if ({misaligned, if_id_valid, if_id_instr, if_id_pc_plus2} !==
                {1'b1, 1'b1, e.instr, e.pcp2}) begin
                n_err++;
                $display("FAIL misaligned_sticky%0d: got mis=%b v=%b instr=%h pc2=%h want 1 1 %h %h",
                         i, misaligned, if_id_valid, if_id_instr, if_id_pc_plus2, e.instr, e.pcp2);
            end
        end
    endtask

    task automatic test_halt();
        branch_taken = 1'b1;
        branch_target = 16'h0010;
        tick();
        branch_taken = 1'b0;
        sb_push(16'h0010);
        tick();
        e = q.pop_front();
        n_cmp++;
        if ({if_id_valid, if_id_instr, if_id_pc_plus2, halted, bus.imem_addr} !==
            {1'b1, e.instr, e.pcp2, 1'b1, 16'h0010}) begin
            n_err++;
            $display("FAIL halt_capture: got v=%b instr=%h pc2=%h halted=%b pc=%h want 1 %h %h 1 0010",
                     if_id_valid, if_id_instr, if_id_pc_plus2, halted, bus.imem_addr, e.instr, e.pcp2);
        end
        stall = 1'b1;
        tick();
        stall = 1'b0;
        n_cmp++;
        if ({if_id_valid, if_id_instr, halted} !== {1'b1, 16'h0000, 1'b1}) begin
            n_err++;
            $display("FAIL halt_stall_hold: got v=%b instr=%h halted=%b want 1 0000 1",
                     if_id_valid, if_id_instr, halted);
        end
        tick();
        n_cmp++;
        if ({if_id_valid, bus.imem_en, halted, if_id_instr, bus.imem_addr} !==
            {1'b0, 1'b0, 1'b1, NOP, 16'h0010}) begin
            n_err++;
            $display("FAIL halted_idle: got v=%b en=%b halted=%b instr=%h pc=%h want 0 0 1 %h 0010",
                     if_id_valid, bus.imem_en, halted, if_id_instr, bus.imem_addr, NOP);
        end
        branch_taken = 1'b1;
        branch_target = 16'h0020;
        tick();
        branch_taken = 1'b0;
        n_cmp++;
        if ({halted, bus.imem_en, bus.imem_addr, if_id_valid} !== {1'b0, 1'b1, 16'h0020, 1'b0}) begin
            n_err++;
            $display("FAIL halt_redirect: got halted=%b en=%b pc=%h v=%b want 0 1 0020 0",
                     halted, bus.imem_en, bus.imem_addr, if_id_valid);
        end
        sb_push(16'h0020);
        tick();
        e = q.pop_front();
        n_cmp++;
        if ({if_id_valid, if_id_instr, if_id_pc_plus2} !== {1'b1, e.instr, e.pcp2}) begin
            n_err++;
            $display("FAIL halt_resume_fetch: got v=%b instr=%h pc2=%h want 1 %h %h",
                     if_id_valid, if_id_instr, if_id_pc_plus2, e.instr, e.pcp2);
        end
    endtask

    task automatic test_wrap();
        branch_taken = 1'b1;
        branch_target = 16'hFFFE;
        tick();
        branch_taken = 1'b0;
        sb_push(16'hFFFE);
        tick();
        e = q.pop_front();
        n_cmp++;
        if ({bus.imem_addr, if_id_valid, if_id_instr, if_id_pc_plus2} !==
            {16'h0000, 1'b1, e.instr, 16'h0000}) begin
            n_err++;
            $display("FAIL wrap: got pc=%h v=%b instr=%h pc2=%h want 0000 1 %h 0000",
                     bus.imem_addr, if_id_valid, if_id_instr, if_id_pc_plus2, e.instr);
        end
    endtask

    task automatic test_back_to_back();
        // Push several expectations ahead, then drain one per edge
        for (int i = 0; i < 6; i++) sb_push(bus.imem_addr + 16'(2 * i));
        for (int i = 0; i < 6; i++) begin
            tick();
            e = q.pop_front();
            n_cmp++;
            if ({if_id_valid, if_id_instr, if_id_pc_plus2} !== {1'b1, e.instr, e.pcp2}) begin
                n_err++;
                $display("FAIL back_to_back%0d: got v=%b instr=%h pc2=%h want 1 %h %h",
                         i, if_id_valid, if_id_instr, if_id_pc_plus2, e.instr, e.pcp2);
            end
        end
    endtask

    task automatic test_midreset_and_boot();
        branch_taken = 1'b1;
        branch_target = 16'h0081;
        stall = 1'b1;
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({bus.imem_addr, if_id_valid, if_id_instr, if_id_pc_plus2, halted, misaligned, bus.imem_en} !==
            {16'h0000, 1'b0, NOP, 16'h0000, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL midreset: got pc=%h v=%b instr=%h pc2=%h halted=%b mis=%b en=%b want reset values",
                     bus.imem_addr, if_id_valid, if_id_instr, if_id_pc_plus2, halted, misaligned, bus.imem_en);
        end
        rst_n = 1'b1;
        tick();
        branch_taken = 1'b0;
        stall = 1'b0;
        n_cmp++;
        if ({bus.imem_addr, bus.imem_en, misaligned, if_id_valid} !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL boot_ignores_inputs: got pc=%h en=%b mis=%b v=%b want 0000 1 0 0",
                     bus.imem_addr, bus.imem_en, misaligned, if_id_valid);
        end
        sb_push(16'h0000);
        tick();
        e = q.pop_front();
        n_cmp++;
        if ({if_id_valid, if_id_instr, if_id_pc_plus2} !== {1'b1, e.instr, e.pcp2}) begin
            n_err++;
            $display("FAIL post_reset_fetch: got v=%b instr=%h pc2=%h want 1 %h %h",
                     if_id_valid, if_id_instr, if_id_pc_plus2, e.instr, e.pcp2);
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'h8800 | (16'(i) & 16'h07FF);
        mem[0]        = 16'h4000;
        mem[1]        = 16'h4001;
        mem[2]        = 16'h4002;
        mem[16'h0008] = 16'h0000;
        mem[16'h7FFF] = 16'h5A5A;

        test_reset();
        test_seq_fetch();
        test_stall();
        test_branch_over_stall();
        test_odd_target();
        test_halt();
        test_wrap();
        test_back_to_back();
        test_midreset_and_boot();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
